// File: rtl/expr_tx.sv
// ---------------------------------------------------------------------------
// expr_tx : transmit-side generator of well-formed ASCII expression streams.
//
// Emits digit (op digit)* with one character per valid/ready handshake.
// Content comes from an 8-bit LFSR that advances only on a transfer and
// carries over from one expression to the next.
//
// Ports
//   clk      in   clock, rising edge
//   clr      in   synchronous active-high reset
//   start    in   request a new expression (sampled only while idle)
//   terms    in   digit count, latched with start (0 -> 1, clipped to MAX_TERMS)
//   ready    in   consumer accepts out this cycle
//   err_pos  in   (EXPR_TX_ERR_INJECT_EN only) 1-based index replaced by '#'
//   out      out  ASCII character, 8'h00 when valid=0
//   valid    out  out holds a character
//   busy     out  expression in progress
//   done     out  one-cycle pulse after the final character transfers
//
// Optional feature: define EXPR_TX_ERR_INJECT_EN to add the err_pos input.
// ---------------------------------------------------------------------------
module expr_tx #(
   parameter logic [7:0]  SEED      = 8'h01,
   parameter int unsigned MAX_TERMS = 15
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [3:0] terms,
   input  logic       ready,
`ifdef EXPR_TX_ERR_INJECT_EN
   input  logic [3:0] err_pos,
`endif
   output logic [7:0] out,
   output logic       valid,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [3:0] MAX_T     = 4'(MAX_TERMS);
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_PLUS   = 8'h2B;
   localparam logic [7:0] CH_STAR   = 8'h2A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIGIT = 2'd1,
      ST_OP    = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  lfsr_q,  lfsr_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [7:0]  out_q,   out_d;
   logic        valid_q, valid_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;
   logic        xfer;
   logic [3:0]  eff_terms;

`ifdef EXPR_TX_ERR_INJECT_EN
   // Stream index needs 5 bits: up to 29 characters per expression.
   logic [4:0]  idx_q, idx_d;
   logic [3:0]  err_q, err_d;
`endif

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Term count normalisation: 0 means one digit, large values clip.
   always_comb begin
      eff_terms = terms;
      if (terms == 4'd0)     eff_terms = 4'd1;
      else if (terms > MAX_T) eff_terms = MAX_T;
   end

   // Next-state logic; outputs are decoded from the next state so that
   // they are registered and line up with the state they describe.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      out_d   = 8'h00;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      xfer    = valid_q & ready;
`ifdef EXPR_TX_ERR_INJECT_EN
      idx_d   = idx_q;
      err_d   = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = eff_terms;
               state_d = ST_DIGIT;
`ifdef EXPR_TX_ERR_INJECT_EN
               idx_d   = 5'd1;
               err_d   = err_pos;
`endif
            end
         end
         ST_DIGIT: begin
            if (xfer) begin
               lfsr_d  = lfsr_step(lfsr_q);
               cnt_d   = cnt_q - 4'd1;
               state_d = (cnt_q == 4'd1) ? ST_FIN : ST_OP;
`ifdef EXPR_TX_ERR_INJECT_EN
               idx_d   = idx_q + 5'd1;
`endif
            end
         end
         ST_OP: begin
            if (xfer) begin
               lfsr_d  = lfsr_step(lfsr_q);
               state_d = ST_DIGIT;
`ifdef EXPR_TX_ERR_INJECT_EN
               idx_d   = idx_q + 5'd1;
`endif
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_DIGIT: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            out_d   = CH_ZERO + (lfsr_d % 8'd10);
         end
         ST_OP: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            out_d   = lfsr_d[0] ? CH_STAR : CH_PLUS;
         end
         ST_FIN: begin
            done_d  = 1'b1;
         end
         default: begin
         end
      endcase

`ifdef EXPR_TX_ERR_INJECT_EN
      // Positions past the stream end never match, so they have no effect.
      if (valid_d && (err_d != 4'd0) && ({1'b0, err_d} == idx_d)) begin
         out_d = 8'h23;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         lfsr_q  <= SEED_EFF;
         cnt_q   <= 4'd0;
         out_q   <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef EXPR_TX_ERR_INJECT_EN
         idx_q   <= 5'd0;
         err_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef EXPR_TX_ERR_INJECT_EN
         idx_q   <= idx_d;
         err_q   <= err_d;
`endif
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_expr_tx.sv
// ---------------------------------------------------------------------------
// tb_expr_tx : scoreboard bench for expr_tx. The driver pushes the expected
// character stream (followed by a done marker) when it issues start; the
// monitor pops on every transfer and on every done pulse.
// ---------------------------------------------------------------------------
module tb_expr_tx;

   localparam logic [7:0] SEED = 8'h01;
   localparam int DONE_MARK = -1;

   logic       clk   = 1'b0;
   logic       clr   = 1'b1;
   logic       start = 1'b0;
   logic [3:0] terms = 4'd0;
   logic       ready = 1'b0;
`ifdef EXPR_TX_ERR_INJECT_EN
   logic [3:0] err_pos = 4'd0;
`endif
   logic [7:0] out;
   logic       valid;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   expr_tx #(.SEED(SEED), .MAX_TERMS(15)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .terms (terms),
      .ready (ready),
`ifdef EXPR_TX_ERR_INJECT_EN
      .err_pos(err_pos),
`endif
      .out   (out),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   int         n_pass  = 0;
   int         n_total = 0;
   int         exp_q[$];
   logic [7:0] m_lfsr  = SEED;
   bit         rand_ready = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
   endtask

   // Reference model: LFSR rule and stream grammar at character level.
   function automatic logic [7:0] adv(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic int eff(input int t);
      if (t == 0) return 1;
      if (t > 15) return 15;
      return t;
   endfunction

   task automatic push_model(input int t, input int ep);
      int n;
      int c;
      n = 2 * eff(t) - 1;
      for (int k = 0; k < n; k++) begin
         if (k % 2 == 0) c = 48 + (int'(m_lfsr) % 10);
         else            c = m_lfsr[0] ? 42 : 43;
         if (ep != 0 && k + 1 == ep) c = 35;
         exp_q.push_back(c);
         m_lfsr = adv(m_lfsr);
      end
      exp_q.push_back(DONE_MARK);
   endtask

   // Literal expectations, right-aligned one byte per character.
   task automatic push_lit(input int t, input logic [39:0] chars);
      int n;
      n = 2 * eff(t) - 1;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(int'(chars[8*(n-1-k) +: 8]));
         m_lfsr = adv(m_lfsr);
      end
      exp_q.push_back(DONE_MARK);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (!busy && !done) break;
         tick();
      end
      check("idle_reached", int'(busy | done), 0);
   endtask

   task automatic start_cmd(input int t);
      wait_idle();
      terms = 4'(t);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      wait_idle();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      exp_q.delete();
      m_lfsr = SEED;
      check("rst_out",   int'(out),   0);
      check("rst_valid", int'(valid), 0);
      check("rst_busy",  int'(busy),  0);
      check("rst_done",  int'(done),  0);
   endtask

   // Monitor: samples on the falling edge, away from input changes.
   bit         done_pending = 1'b0;
   bit         stall_prev   = 1'b0;
   logic [8:0] prev_vo      = 9'd0;
   bit         mark_ok;
   int         e;

   initial begin
      forever begin
         @(negedge clk);
         if (clr) begin
            done_pending = 1'b0;
            stall_prev   = 1'b0;
         end else begin
            if (done_pending) begin
               check("done_after_last", int'(done), 1);
               done_pending = 1'b0;
            end
            if (done) begin
               mark_ok = (exp_q.size() > 0) && (exp_q[0] == DONE_MARK);
               check("done_expected", int'(mark_ok), 1);
               if (mark_ok) void'(exp_q.pop_front());
               check("done_busy_low", int'(busy), 0);
            end
            if (!valid) check("out_zero_idle", int'(out), 0);
            if (stall_prev) check("stall_hold", int'({valid, out}), int'(prev_vo));
            if (valid && ready) begin
               if (exp_q.size() == 0 || exp_q[0] == DONE_MARK) begin
                  check("unexpected_char", int'(out), DONE_MARK);
               end else begin
                  e = exp_q.pop_front();
                  check("char", int'(out), e);
                  if (exp_q.size() > 0 && exp_q[0] == DONE_MARK) done_pending = 1'b1;
               end
            end
            stall_prev = valid && !ready;
            prev_vo    = {valid, out};
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int t;
   int ep;

   initial begin
      // Reset state.
      do_reset();

      // terms=3 with ready=1, plus a start pulse landing in the done cycle.
      ready = 1'b1;
      push_lit(3, 40'h312B342B37);
      start_cmd(3);
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         tick();
      end
      check("done_seen", int'(done), 1);
      terms = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_fin_ignored", int'(busy), 0);

      // Two expressions back to back; LFSR continues.
      do_reset();
      push_lit(2, 40'h312B34);
      start_cmd(2);
      push_lit(1, 40'h38);
      start_cmd(1);

      // Back-pressure on the first character.
      do_reset();
      ready = 1'b0;
      push_lit(2, 40'h312B34);
      start_cmd(2);
      for (int i = 0; i < 4; i++) begin
         check("stall_out",   int'(out),   'h31);
         check("stall_valid", int'(valid), 1);
         tick();
      end
      ready = 1'b1;

      // clr during the second character abandons the stream.
      do_reset();
      ready = 1'b1;
      push_lit(3, 40'h312B342B37);
      start_cmd(3);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_q.delete();
      m_lfsr = SEED;
      check("clr_valid", int'(valid), 0);
      check("clr_busy",  int'(busy),  0);
      check("clr_done",  int'(done),  0);
      push_lit(1, 40'h31);
      start_cmd(1);

      // terms=0 with start pulsed while busy.
      do_reset();
      ready = 1'b0;
      push_lit(0, 40'h31);
      start_cmd(0);
      terms = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_during_ignore", int'(busy), 1);
      check("out_during_ignore",  int'(out),  'h31);
      ready = 1'b1;

`ifdef EXPR_TX_ERR_INJECT_EN
      // Error injection at position 2.
      do_reset();
      err_pos = 4'd2;
      push_lit(3, 40'h31232B342B37 & 40'hFFFFFFFFFF);
      exp_q.delete();
      m_lfsr = SEED;
      push_lit(3, 40'h3123342B37);
      start_cmd(3);
      wait_idle();
      err_pos = 4'd0;
`endif

      // Randomised expressions with random back-pressure.
      do_reset();
      rand_ready = 1'b1;
      for (int n = 0; n < 25; n++) begin
         t  = $urandom_range(0, 15);
         ep = 0;
`ifdef EXPR_TX_ERR_INJECT_EN
         ep = $urandom_range(0, 15);
         wait_idle();
         err_pos = 4'(ep);
`endif
         push_model(t, ep);
         start_cmd(t);
      end
      wait_idle();
      rand_ready = 1'b0;
      ready = 1'b1;
      tick();
      tick();
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
